// File: rtl/cond_unit_if.sv
// Bus bundle between the EX-stage decode/ALU side and the pipelined condition
// unit. The master side drives the instruction and returning long-op flags.
// The slave side, the condition unit, answers with gated requests, the stall,
// the architectural flags and the counters.
interface cond_unit_if #(
   parameter int CNT_W = 16
);
   logic             Valid;
   logic             Flush;
   logic [3:0]       Cond;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic [1:0]       FlagW;
   logic [3:0]       ALUFlags;
   logic             LongOp;
   logic             LongFlagsValid;
   logic [3:0]       LongFlags;
   logic             PCSrc;
   logic             RegWrite;
   logic             MemWrite;
   logic             CondEx;
   logic             FlagStall;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] ExecCount;
   logic [CNT_W-1:0] SkipCount;
   logic             ProtoErr;

   modport master (
      output Valid, Flush, Cond, PCS, RegW, MemW, FlagW, ALUFlags,
             LongOp, LongFlagsValid, LongFlags,
      input  PCSrc, RegWrite, MemWrite, CondEx, FlagStall, Flags,
             ExecCount, SkipCount, ProtoErr
   );

   modport slave (
      input  Valid, Flush, Cond, PCS, RegW, MemW, FlagW, ALUFlags,
             LongOp, LongFlagsValid, LongFlags,
      output PCSrc, RegWrite, MemWrite, CondEx, FlagStall, Flags,
             ExecCount, SkipCount, ProtoErr
   );
endinterface

// File: rtl/cond_unit_pipe.sv
// Pipelined condition unit for the EX stage. It owns the NZCV register and
// keeps a FIFO of flag-group masks for long-latency ops still in flight.
// Conditional instructions that depend on an in-flight group are stalled.
// Flags returning from a long op are bypassed into the evaluation in the
// cycle they arrive. Saturating executed/skipped counters are also kept.
module cond_unit_pipe #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic     CLK,
   input logic     RESET,
   cond_unit_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [1:0]       fifoMem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W:0]   count;

   logic [3:0]       flagsReg;
   logic [3:0]       nextFlags;
   logic [3:0]       effFlags;
   logic [CNT_W-1:0] execCnt;
   logic [CNT_W-1:0] skipCnt;
   logic             protoErr;

   logic [1:0]       headMask;
   logic [1:0]       pendMask;
   logic [1:0]       needGrp;
   logic             condTrue;
   logic             fifoEmpty;
   logic             fifoFull;
   logic             pop;
   logic             push;
   logic             stall;
   logic             issue;
   logic             condEx;

   assign fifoEmpty = (count == '0);
   assign fifoFull  = (count == (PTR_W+1)'(DEPTH));
   assign headMask  = fifoMem[rdPtr];
   assign pop       = bus.LongFlagsValid & ~fifoEmpty;

   // OR the masks of every live entry; the head drops out when its flags are returning now
   always_comb begin
      pendMask = 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PTR_W+1)'(i) < count) && !((i == 0) && bus.LongFlagsValid)) begin
            pendMask = pendMask | fifoMem[rdPtr + PTR_W'(i)];
         end
      end
   end

   // Bypass returning long-op flags into the groups the head entry owns
   always_comb begin
      effFlags = flagsReg;
      if (pop) begin
         if (headMask[1]) effFlags[3:2] = bus.LongFlags[3:2];
         if (headMask[0]) effFlags[1:0] = bus.LongFlags[1:0];
      end
   end

   // Evaluate the condition field and report which flag groups it reads ({NZ,CV})
   always_comb begin
      condTrue = 1'b1;
      needGrp  = 2'b00;
      case (bus.Cond)
         4'h0: begin condTrue =  effFlags[2];                    needGrp = 2'b10; end
         4'h1: begin condTrue = ~effFlags[2];                    needGrp = 2'b10; end
         4'h2: begin condTrue =  effFlags[1];                    needGrp = 2'b01; end
         4'h3: begin condTrue = ~effFlags[1];                    needGrp = 2'b01; end
         4'h4: begin condTrue =  effFlags[3];                    needGrp = 2'b10; end
         4'h5: begin condTrue = ~effFlags[3];                    needGrp = 2'b10; end
         4'h6: begin condTrue =  effFlags[0];                    needGrp = 2'b01; end
         4'h7: begin condTrue = ~effFlags[0];                    needGrp = 2'b01; end
         4'h8: begin condTrue =  effFlags[1] & ~effFlags[2];     needGrp = 2'b11; end
         4'h9: begin condTrue = ~effFlags[1] |  effFlags[2];     needGrp = 2'b11; end
         4'hA: begin condTrue = (effFlags[3] == effFlags[0]);    needGrp = 2'b11; end
         4'hB: begin condTrue = (effFlags[3] != effFlags[0]);    needGrp = 2'b11; end
         4'hC: begin condTrue = ~effFlags[2] & (effFlags[3] == effFlags[0]); needGrp = 2'b11; end
         4'hD: begin condTrue =  effFlags[2] | (effFlags[3] != effFlags[0]); needGrp = 2'b11; end
         default: begin condTrue = 1'b1; needGrp = 2'b00; end
      endcase
   end

   // Stall on a read of an in-flight group, a write racing one (WAW), or a full FIFO with no pop
   always_comb begin
      stall = 1'b0;
      if (bus.Valid && !bus.Flush && !RESET) begin
         stall = ((needGrp & pendMask) != 2'b00)
               | ((bus.FlagW & pendMask) != 2'b00)
               | (bus.LongOp & fifoFull & ~pop);
      end
   end

   assign issue  = bus.Valid & ~bus.Flush & ~stall & ~RESET;
   assign condEx = issue & condTrue;
   assign push   = condEx & bus.LongOp;

   // Retiring long-op flags land first, then a younger short op overrides any shared group
   always_comb begin
      nextFlags = flagsReg;
      if (pop) begin
         if (headMask[1]) nextFlags[3:2] = bus.LongFlags[3:2];
         if (headMask[0]) nextFlags[1:0] = bus.LongFlags[1:0];
      end
      if (condEx && !bus.LongOp) begin
         if (bus.FlagW[1]) nextFlags[3:2] = bus.ALUFlags[3:2];
         if (bus.FlagW[0]) nextFlags[1:0] = bus.ALUFlags[1:0];
      end
   end

   // Pending-mask FIFO storage; entries are only read while counted as live
   always_ff @(posedge CLK) begin
      if (push) fifoMem[wrPtr] <= bus.FlagW;
   end

   // FIFO pointers and occupancy; a reset throws away everything in flight
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Architectural flags, saturating counters and the sticky protocol-error bit
   always_ff @(posedge CLK) begin
      if (RESET) begin
         flagsReg <= 4'b0000;
         execCnt  <= '0;
         skipCnt  <= '0;
         protoErr <= 1'b0;
      end else begin
         flagsReg <= nextFlags;
         if (condEx && (execCnt != '1)) execCnt <= execCnt + CNT_W'(1);
         if (issue && !condTrue && (skipCnt != '1)) skipCnt <= skipCnt + CNT_W'(1);
         if (bus.LongFlagsValid && fifoEmpty) protoErr <= 1'b1;
      end
   end

   assign bus.CondEx    = condEx;
   assign bus.FlagStall = stall;
   assign bus.PCSrc     = bus.PCS  & condEx;
   assign bus.RegWrite  = bus.RegW & condEx;
   assign bus.MemWrite  = bus.MemW & condEx;
   assign bus.Flags     = flagsReg;
   assign bus.ExecCount = execCnt;
   assign bus.SkipCount = skipCnt;
   assign bus.ProtoErr  = protoErr;
endmodule
